// File: rtl/ldtu_data32_rx_aligner_if.sv
// Lane-side bundle for the LDTU 32-bit receive aligner: raw deserialized words in,
// aligned/tagged words and lock status out.
interface ldtu_data32_rx_aligner_if;
   logic        TEST_ENABLE;
   logic [31:0] RX_WORD;
   logic        RX_VALID;
   logic [31:0] DATA_OUT;
   logic        DATA_VALID;
   logic        IDLE_FLAG;
   logic        LOCKED;
   logic [4:0]  BIT_OFFSET;
   logic [15:0] ERR_COUNT;

   // master: deserializer/checker side, slave: the aligner itself
   modport master (
      output TEST_ENABLE, RX_WORD, RX_VALID,
      input  DATA_OUT, DATA_VALID, IDLE_FLAG, LOCKED, BIT_OFFSET, ERR_COUNT
   );
   modport slave (
      input  TEST_ENABLE, RX_WORD, RX_VALID,
      output DATA_OUT, DATA_VALID, IDLE_FLAG, LOCKED, BIT_OFFSET, ERR_COUNT
   );
endinterface

// File: rtl/ldtu_data32_rx_aligner.sv
// Receive-side word aligner for one LDTU 32-bit lane: hunts the idle pattern over all 32
// bit rotations, verifies it LOCK_COUNT times, then emits aligned, idle-tagged words.
module ldtu_data32_rx_aligner #(
   parameter int          Nbits_32       = 32,
   parameter logic [31:0] idle_patternEA = 32'hEAAA_AAAA,
   parameter logic [31:0] idle_pattern5A = 32'h5A5A_5A5A,
   parameter int          LOCK_COUNT     = 8,
   parameter int          IDLE_TIMEOUT   = 1024,
   parameter logic [15:0] ERR_MAX        = 16'hFFFF
) (
   input  logic                      CLK,
   input  logic                      RST,
   ldtu_data32_rx_aligner_if.slave   bus
);
   localparam int OW = $clog2(Nbits_32);
   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic [1:0]          state_reg, state_next;
   logic [Nbits_32-1:0] prev_reg, prev_next;
   logic                prev_valid_reg, prev_valid_next;
   logic [OW-1:0]       offset_reg, offset_next;
   logic [7:0]          match_cnt_reg, match_cnt_next;
   logic [31:0]         idle_cnt_reg, idle_cnt_next;
   logic [Nbits_32-1:0] data_out_reg, data_out_next;
   logic                data_valid_reg, data_valid_next;
   logic                idle_flag_reg, idle_flag_next;
   logic [15:0]         err_reg, err_next;
   logic                te_reg;

   logic [Nbits_32-1:0] idle_word;
   logic                te_changed;
   logic [Nbits_32-1:0] aligned [Nbits_32];
   logic [Nbits_32-1:0] hit;
   logic [OW-1:0]       hunt_k;
   // RX_WORD bit 0 never lands in a window (k=31 stops at bit 1), so it is left out here
   logic [2*Nbits_32-2:0] cat;

   assign idle_word  = bus.TEST_ENABLE ? idle_pattern5A : idle_patternEA;
   assign te_changed = bus.TEST_ENABLE != te_reg;
   assign cat        = {prev_reg, bus.RX_WORD[Nbits_32-1:1]};

   genvar gi;
   generate
      for (gi = 0; gi < Nbits_32; gi++) begin : g_window
         assign aligned[gi] = cat[2*Nbits_32-2-gi -: Nbits_32];
         assign hit[gi]     = aligned[gi] == idle_word;
      end
   endgenerate

   // lowest matching rotation wins (5A is 8-bit periodic, so several k can match)
   always_comb begin
      hunt_k = '0;
      for (int i = Nbits_32 - 1; i >= 0; i--) begin
         if (hit[i]) hunt_k = OW'(i);
      end
   end

   always_comb begin
      state_next      = state_reg;
      prev_next       = prev_reg;
      prev_valid_next = prev_valid_reg;
      offset_next     = offset_reg;
      match_cnt_next  = match_cnt_reg;
      idle_cnt_next   = idle_cnt_reg;
      data_out_next   = data_out_reg;
      data_valid_next = 1'b0;
      idle_flag_next  = 1'b0;
      err_next        = err_reg;
      if (te_changed) begin
         state_next      = ST_HUNT;
         prev_valid_next = 1'b0;
         offset_next     = '0;
         if (state_reg == ST_LOCKED && err_reg != ERR_MAX) err_next = err_reg + 16'd1;
      end else if (bus.RX_VALID) begin
         prev_next = bus.RX_WORD;
         case (state_reg)
            ST_HUNT: begin
               if (!prev_valid_reg) begin
                  prev_valid_next = 1'b1;
               end else if (|hit) begin
                  offset_next    = hunt_k;
                  match_cnt_next = 8'd1;
                  if (LOCK_COUNT == 1) begin
                     state_next    = ST_LOCKED;
                     idle_cnt_next = '0;
                  end else begin
                     state_next = ST_VERIFY;
                  end
               end
            end
            ST_VERIFY: begin
               if (hit[offset_reg]) begin
                  match_cnt_next = match_cnt_reg + 8'd1;
                  if (match_cnt_next == 8'(LOCK_COUNT)) begin
                     state_next    = ST_LOCKED;
                     idle_cnt_next = '0;
                  end
               end else begin
                  state_next      = ST_HUNT;
                  offset_next     = '0;
                  prev_valid_next = 1'b0;
               end
            end
            ST_LOCKED: begin
               data_out_next   = aligned[offset_reg];
               data_valid_next = 1'b1;
               idle_flag_next  = hit[offset_reg];
               if (hit[offset_reg]) begin
                  idle_cnt_next = '0;
               end else begin
                  idle_cnt_next = idle_cnt_reg + 32'd1;
                  // the word that trips the timeout is still emitted above
                  if (IDLE_TIMEOUT != 0 && idle_cnt_next == 32'(IDLE_TIMEOUT)) begin
                     state_next      = ST_HUNT;
                     offset_next     = '0;
                     prev_valid_next = 1'b0;
                     if (err_reg != ERR_MAX) err_next = err_reg + 16'd1;
                  end
               end
            end
            default: begin
               state_next      = ST_HUNT;
               offset_next     = '0;
               prev_valid_next = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg      <= ST_HUNT;
         prev_reg       <= '0;
         prev_valid_reg <= 1'b0;
         offset_reg     <= '0;
         match_cnt_reg  <= '0;
         idle_cnt_reg   <= '0;
         data_out_reg   <= '0;
         data_valid_reg <= 1'b0;
         idle_flag_reg  <= 1'b0;
         err_reg        <= '0;
         te_reg         <= bus.TEST_ENABLE;
      end else begin
         state_reg      <= state_next;
         prev_reg       <= prev_next;
         prev_valid_reg <= prev_valid_next;
         offset_reg     <= offset_next;
         match_cnt_reg  <= match_cnt_next;
         idle_cnt_reg   <= idle_cnt_next;
         data_out_reg   <= data_out_next;
         data_valid_reg <= data_valid_next;
         idle_flag_reg  <= idle_flag_next;
         err_reg        <= err_next;
         te_reg         <= bus.TEST_ENABLE;
      end
   end

   assign bus.DATA_OUT   = data_out_reg;
   assign bus.DATA_VALID = data_valid_reg;
   assign bus.IDLE_FLAG  = idle_flag_reg;
   assign bus.LOCKED     = state_reg == ST_LOCKED;
   assign bus.BIT_OFFSET = offset_reg;
   assign bus.ERR_COUNT  = err_reg;
endmodule

// File: tb/tb_ldtu_data32_rx_aligner.sv
// Directed bench for ldtu_data32_rx_aligner: a table of stream vectors for lock/data,
// then hand sequences for timeout, verify abort, mode switch, reset and saturation.
module tb_ldtu_data32_rx_aligner;
   localparam logic [31:0] EA  = 32'hEAAA_AAAA;
   localparam logic [31:0] P5A = 32'h5A5A_5A5A;

   typedef struct {
      logic        valid;
      logic [31:0] lword;
      logic        dv;
      logic        idle;
      logic [31:0] data;
      logic        locked;
      logic [4:0]  off;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ldtu_data32_rx_aligner_if mif ();
   ldtu_data32_rx_aligner_if sif ();

   ldtu_data32_rx_aligner #(.LOCK_COUNT(8), .IDLE_TIMEOUT(16)) u_dut (
      .CLK(clk), .RST(rst), .bus(mif)
   );
   ldtu_data32_rx_aligner #(.LOCK_COUNT(1), .IDLE_TIMEOUT(1), .ERR_MAX(16'd3)) u_sat (
      .CLK(clk), .RST(rst), .bus(sif)
   );

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] log_prev;
   int          rot;
   vec_t        tbl [15];

   // raw lane word carrying logical word c when the bitstream is shifted by k
   function automatic logic [31:0] raw_of(input logic [31:0] p, input logic [31:0] c, input int k);
      logic [63:0] cc;
      cc = {p, c} >> k;
      return cc[31:0];
   endfunction

   task automatic step(input logic te, input logic v, input logic [31:0] w);
      @(negedge clk);
      mif.TEST_ENABLE = te;
      mif.RX_VALID    = v;
      mif.RX_WORD     = w;
      @(posedge clk);
      #1;
   endtask

   task automatic send_log(input logic te, input logic [31:0] l);
      logic [31:0] w;
      w = raw_of(log_prev, l, rot);
      log_prev = l;
      step(te, 1'b1, w);
   endtask

   task automatic check(input string name, input logic dv, input logic idle, input logic [31:0] data,
                        input logic locked, input logic [4:0] off, input logic [15:0] err);
      n_vec++;
      if (mif.DATA_VALID !== dv || mif.IDLE_FLAG !== idle || mif.DATA_OUT !== data ||
          mif.LOCKED !== locked || mif.BIT_OFFSET !== off || mif.ERR_COUNT !== err) begin
         n_bad++;
         $display("FAIL %s: got dv=%b idle=%b data=%h lock=%b off=%0d err=%0d, want dv=%b idle=%b data=%h lock=%b off=%0d err=%0d",
                  name, mif.DATA_VALID, mif.IDLE_FLAG, mif.DATA_OUT, mif.LOCKED, mif.BIT_OFFSET,
                  mif.ERR_COUNT, dv, idle, data, locked, off, err);
      end else begin
         $display("[%0t] %s ok", $time, name);
      end
   endtask

   task automatic check_state(input string name, input logic locked, input logic [4:0] off,
                              input logic [15:0] err);
      n_vec++;
      if (mif.LOCKED !== locked || mif.BIT_OFFSET !== off || mif.ERR_COUNT !== err) begin
         n_bad++;
         $display("FAIL %s: got lock=%b off=%0d err=%0d, want lock=%b off=%0d err=%0d",
                  name, mif.LOCKED, mif.BIT_OFFSET, mif.ERR_COUNT, locked, off, err);
      end else begin
         $display("[%0t] %s ok", $time, name);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      mif.RX_VALID = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      mif.TEST_ENABLE = 1'b0;
      mif.RX_VALID    = 1'b0;
      mif.RX_WORD     = '0;
      sif.TEST_ENABLE = 1'b0;
      sif.RX_VALID    = 1'b0;
      sif.RX_WORD     = '0;

      for (int i = 0; i < 9; i++)
         tbl[i] = '{1'b1, EA, 1'b0, 1'b0, 32'h0, (i == 8), (i == 0) ? 5'd0 : 5'd13};
      tbl[9]  = '{1'b1, EA,            1'b1, 1'b1, EA,            1'b1, 5'd13};
      tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b0, EA,            1'b1, 5'd13};
      tbl[11] = '{1'b1, 32'h1234_5678, 1'b1, 1'b1, EA,            1'b1, 5'd13};
      tbl[12] = '{1'b0, 32'h0,         1'b0, 1'b0, EA,            1'b1, 5'd13};
      tbl[13] = '{1'b1, EA,            1'b1, 1'b0, 32'h1234_5678, 1'b1, 5'd13};
      tbl[14] = '{1'b1, EA,            1'b1, 1'b1, EA,            1'b1, 5'd13};

      // reset state
      do_reset();
      check("reset", 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 16'd0);

      // VERIFY aborted by a corrupted 5th idle: back to HUNT, no error counted
      rot = 13; log_prev = EA;
      for (int i = 0; i < 4; i++) send_log(1'b0, EA);
      send_log(1'b0, EA ^ 32'h1);
      check_state("verify_4_matches", 1'b0, 5'd13, 16'd0);
      send_log(1'b0, EA);
      check_state("verify_abort", 1'b0, 5'd0, 16'd0);

      // lock on rotation 13, then data injection with RX_VALID gaps
      do_reset();
      rot = 13; log_prev = EA;
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].valid) send_log(1'b0, tbl[i].lword);
         else              step(1'b0, 1'b0, 32'hFFFF_FFFF);
         check($sformatf("tbl%0d", i), tbl[i].dv, tbl[i].idle, tbl[i].data, tbl[i].locked,
               tbl[i].off, 16'd0);
      end

      // 16 non-idle words in a row trip the idle timeout
      for (int j = 1; j <= 17; j++) begin
         send_log(1'b0, 32'h1000_0000 + (32'(j) << 16));
         if (j == 16)
            check("timeout_minus1", 1'b1, 1'b0, 32'h100F_0000, 1'b1, 5'd13, 16'd0);
      end
      check("timeout_hit", 1'b1, 1'b0, 32'h1010_0000, 1'b0, 5'd0, 16'd1);
      for (int i = 0; i < 9; i++) begin
         send_log(1'b0, EA);
         if (i == 7) check_state("relock_pending", 1'b0, 5'd13, 16'd1);
      end
      check_state("relock", 1'b1, 5'd13, 16'd1);
      send_log(1'b0, EA);
      check("relock_data", 1'b1, 1'b1, EA, 1'b1, 5'd13, 16'd1);

      // TEST_ENABLE change while locked, then lock on a 5A stream at rotation 3
      step(1'b1, 1'b0, 32'h0);
      check("te_toggle", 1'b0, 1'b0, EA, 1'b0, 5'd0, 16'd2);
      rot = 3; log_prev = P5A;
      for (int i = 0; i < 9; i++) begin
         send_log(1'b1, P5A);
         if (i == 7) check_state("lock5a_pending", 1'b0, 5'd3, 16'd2);
      end
      check_state("lock5a", 1'b1, 5'd3, 16'd2);
      send_log(1'b1, P5A);
      check("lock5a_data", 1'b1, 1'b1, P5A, 1'b1, 5'd3, 16'd2);

      // reset while locked with a valid word present
      @(negedge clk);
      rst = 1'b1;
      mif.RX_VALID = 1'b1;
      mif.RX_WORD  = raw_of(P5A, P5A, 3);
      @(posedge clk);
      #1;
      check("rst_midlock", 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      mif.RX_VALID = 1'b0;

      // saturation: instance with a ceiling of 3, lose lock five times
      for (int loss = 1; loss <= 5; loss++) begin
         for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            sif.RX_VALID = 1'b1;
            sif.RX_WORD  = (w < 2) ? EA : 32'h0;
            @(posedge clk);
            #1;
         end
         n_vec++;
         if (sif.ERR_COUNT !== 16'((loss < 3) ? loss : 3) || sif.LOCKED !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_loss%0d: got err=%0d lock=%b, want err=%0d lock=0",
                     loss, sif.ERR_COUNT, sif.LOCKED, (loss < 3) ? loss : 3);
         end else begin
            $display("[%0t] sat_loss%0d ok", $time, loss);
         end
      end
      @(negedge clk);
      sif.RX_VALID = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
